// File: rtl/debug_host_scanner.sv
// Debug-port initiator: halts/steps the CPU and sweeps all debug addresses into a snapshot RAM.
// All outputs registered; display read has 1-cycle latency; step requests outside IDLE are dropped.
module debug_host_scanner #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 32,
  parameter int STEP_CYCLES = 4,
  parameter int SETTLE      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_mode,
  input  logic                  step_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  debug_en,
  output logic                  debug_step,
  output logic [ADDR_WIDTH-1:0] debug_addr,
  input  logic [DATA_WIDTH-1:0] debug_data,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic                  snap_valid,
  output logic [15:0]           step_count
);

  localparam int CNT_MAX = (STEP_CYCLES > SETTLE + 1) ? STEP_CYCLES : SETTLE + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]         STEP_LAST   = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0]         SETTLE_LAST = CW'(SETTLE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST   = '1;

  typedef enum logic [2:0] {IDLE, STEP_HI, STEP_LO, SCAN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic                  debug_en_q, debug_en_d;
  logic                  debug_step_q, debug_step_d;
  logic [ADDR_WIDTH-1:0] debug_addr_q, debug_addr_d;
  logic                  scan_busy_q, scan_busy_d;
  logic                  scan_done_q, scan_done_d;
  logic                  snap_valid_q, snap_valid_d;
  logic [15:0]           step_count_q, step_count_d;
  logic [DATA_WIDTH-1:0] disp_data_q, disp_data_d;
  logic [DATA_WIDTH-1:0] snap_mem [2**ADDR_WIDTH];
  logic                  step_edge;
  logic                  capture;

  assign step_edge = sync2_q & ~sync3_q;
  assign capture   = (state_q == SCAN) && (cnt_q == SETTLE_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run_mode)       state_d = SCAN;
        else if (step_edge) state_d = STEP_HI;
      end
      STEP_HI: if (cnt_q == STEP_LAST) state_d = STEP_LO;
      STEP_LO: if (cnt_q == STEP_LAST) state_d = SCAN;
      SCAN:    if (capture && debug_addr_q == ADDR_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync1_d = step_req;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    cnt_d   = cnt_q + 1'b1;
    if (state_q == IDLE || state_d != state_q || capture) cnt_d = '0;
    debug_addr_d = debug_addr_q;
    if (capture)          debug_addr_d = debug_addr_q + 1'b1;
    if (state_d == IDLE)  debug_addr_d = '0;
    // Mode only latches while idle so it stays stable across a step or sweep.
    debug_en_d   = (state_q == IDLE) ? ~run_mode : debug_en_q;
    debug_step_d = (state_d == STEP_HI);
    scan_busy_d  = (state_d != IDLE);
    scan_done_d  = (state_d == DONE);
    snap_valid_d = snap_valid_q | (state_d == DONE);
    step_count_d = step_count_q;
    if (state_q == STEP_HI && state_d == STEP_LO) step_count_d = step_count_q + 16'd1;
    disp_data_d  = snap_mem[disp_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      debug_en_q   <= 1'b1;
      debug_step_q <= 1'b0;
      debug_addr_q <= '0;
      scan_busy_q  <= 1'b0;
      scan_done_q  <= 1'b0;
      snap_valid_q <= 1'b0;
      step_count_q <= '0;
      disp_data_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      debug_en_q   <= debug_en_d;
      debug_step_q <= debug_step_d;
      debug_addr_q <= debug_addr_d;
      scan_busy_q  <= scan_busy_d;
      scan_done_q  <= scan_done_d;
      snap_valid_q <= snap_valid_d;
      step_count_q <= step_count_d;
      disp_data_q  <= disp_data_d;
    end
  end

  // Snapshot contents survive reset; a read colliding with a write sees the old word.
  always_ff @(posedge clk) begin
    if (capture && !reset) snap_mem[debug_addr_q] <= debug_data;
  end

  assign disp_data  = disp_data_q;
  assign debug_en   = debug_en_q;
  assign debug_step = debug_step_q;
  assign debug_addr = debug_addr_q;
  assign scan_busy  = scan_busy_q;
  assign scan_done  = scan_done_q;
  assign snap_valid = snap_valid_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_debug_host_scanner.sv
// Bench for debug_host_scanner: step timing, sweep pattern, snapshot reads, continuous mode, reset abort, counter wrap.
module tb_debug_host_scanner;

  logic        clk = 1'b0;
  logic        reset, run_mode, step_req;
  logic [6:0]  disp_addr;
  logic [31:0] disp_data;
  logic        debug_en, debug_step;
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
  logic        scan_busy, scan_done, snap_valid;
  logic [15:0] step_count;
  logic [31:0] key;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q [$];
  logic        step_mon = 1'b0;
  int          step_seen = 0;

  always #5 clk = ~clk;

  assign debug_data = {25'h0, debug_addr} ^ key;

  debug_host_scanner dut (
    .clk(clk), .reset(reset), .run_mode(run_mode), .step_req(step_req),
    .disp_addr(disp_addr), .disp_data(disp_data), .debug_en(debug_en),
    .debug_step(debug_step), .debug_addr(debug_addr), .debug_data(debug_data),
    .scan_busy(scan_busy), .scan_done(scan_done), .snap_valid(snap_valid),
    .step_count(step_count)
  );

  always @(negedge clk) if (step_mon && debug_step) step_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_snap(input logic [6:0] a, input logic [31:0] e);
    disp_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    check("disp_data", disp_data, exp_q.pop_front());
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    repeat (2) @(negedge clk);
    step_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < budget);
    check(tag, scan_done, 1'b1);
  endtask

  task automatic wait_addr(input logic [6:0] a, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (debug_addr != a && n < budget);
    check("wait_addr", debug_addr, a);
  endtask

  task automatic check_reset_values();
    check("rst_debug_en", debug_en, 1'b1);
    check("rst_debug_step", debug_step, 1'b0);
    check("rst_debug_addr", debug_addr, 7'd0);
    check("rst_disp_data", disp_data, 32'd0);
    check("rst_scan_busy", scan_busy, 1'b0);
    check("rst_scan_done", scan_done, 1'b0);
    check("rst_snap_valid", snap_valid, 1'b0);
    check("rst_step_count", step_count, 16'd0);
  endtask

  initial begin
    int n, h, l, first1, runs, run, bad, en_low;
    logic [6:0] prev;

    reset = 1'b1; run_mode = 1'b0; step_req = 1'b0; disp_addr = '0;
    key = 32'hA5A5_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();

    // Single step: edge latency, step pulse widths, sweep cadence.
    reset = 1'b0;
    step_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!debug_step && n < 20);
    check("edge_latency", n, 3);
    h = 0;
    while (debug_step && h < 20) begin
      h++;
      @(negedge clk);
    end
    check("step_hi_width", h, 4);
    step_req = 1'b0;
    l = 0; first1 = -1; runs = 0; run = 0; bad = 0; en_low = 0; prev = '0;
    while (!scan_done && l < 1000) begin
      if (!debug_en) en_low++;
      if (debug_addr != prev) begin
        if (prev != 0 && run != 3) bad++;
        if (debug_addr != prev + 7'd1) bad++;
        if (debug_addr == 7'd1) first1 = l;
        runs++;
        run = 1;
        prev = debug_addr;
      end else begin
        run++;
      end
      l++;
      @(negedge clk);
    end
    check("step_lo_plus_settle", first1, 7);
    check("low_to_done", l, 388);
    check("addr_runs", runs, 127);
    check("addr_bad_runs", bad, 0);
    check("last_addr", prev, 7'd127);
    check("last_run", run, 3);
    check("debug_en_low", en_low, 0);
    check("done_pulse", scan_done, 1'b1);
    @(negedge clk);
    check("done_one_cycle", scan_done, 1'b0);
    check("snap_valid", snap_valid, 1'b1);
    check("step_count_1", step_count, 16'd1);
    check("debug_en_hold", debug_en, 1'b1);

    read_snap(7'd0,   32'hA5A5_0000);
    read_snap(7'd5,   32'hA5A5_0005);
    read_snap(7'd127, 32'hA5A5_007F);

    // Steps requested mid-sweep are dropped, not queued.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_step();
    wait_addr(7'd20, 200);
    repeat (3) pulse_step();
    wait_done("done_a", 1000, n);
    repeat (10) @(negedge clk);
    check("no_queued_step", scan_busy, 1'b0);
    pulse_step();
    wait_done("done_b", 1000, n);
    @(negedge clk);
    check("step_count_2", step_count, 16'd2);

    // Free-running: continuous back-to-back sweeps, no step pulses.
    repeat (3) @(negedge clk);
    step_mon = 1'b1;
    run_mode = 1'b1;
    @(negedge clk);
    check("run_debug_en", debug_en, 1'b0);
    check("run_busy", scan_busy, 1'b1);
    wait_done("run_done_1", 1000, n);
    wait_done("run_done_2", 1000, n);
    check("run_period", n, 386);
    wait_done("run_done_3", 1000, n);
    check("run_period_2", n, 386);
    wait_addr(7'd50, 500);
    run_mode = 1'b0;
    wait_done("run_done_last", 1000, n);
    check("run_debug_en_still", debug_en, 1'b0);
    repeat (2) @(negedge clk);
    check("halt_debug_en", debug_en, 1'b1);
    check("halt_idle", scan_busy, 1'b0);
    step_mon = 1'b0;
    check("run_no_step", step_seen, 0);
    check("run_step_count", step_count, 16'd2);

    // Reset in mid-sweep: abort, keep RAM contents.
    key = 32'h1234_0000;
    pulse_step();
    wait_addr(7'd60, 500);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    read_snap(7'd10,  32'h1234_000A);
    read_snap(7'd60,  32'hA5A5_003C);
    read_snap(7'd100, 32'hA5A5_0064);

    // Step counter wrap.
    force dut.step_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.step_count_q;
    @(negedge clk);
    check("preload", step_count, 16'hFFFF);
    pulse_step();
    wait_done("wrap_done", 1000, n);
    check("wrap_count", step_count, 16'h0000);
    check("wrap_valid", snap_valid, 1'b1);
    @(negedge clk);
    read_snap(7'd127, 32'h1234_007F);
    read_snap(7'd60,  32'h1234_003C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
